io_stream_port: RTL and testbench
=================================

Name: io_stream_port

Overview:
- IO-bus responder for the NeonFox CPU's IO space.
- The CPU drives IO_address, its read/write strobes and byte-lane enables. This block answers reads on DIO_out with one cycle of latency, which is what the CPU register file's DIO_in path expects.
- CPU writes to the DATA register feed a TX FIFO that drains to an external valid/ready stream.
- An external RX stream fills an RX FIFO that the CPU pops by reading DATA.
- Also provides status, control and an interrupt.

Parameters:
- BASE_ADDR, 16'hFF00: IO base address. The block decodes IO_address[15:2] == BASE_ADDR[15:2]; offset is IO_address[1:0].
- DEPTH, 8: entries per FIFO, each 16 bits. Must be a power of 2, range 2..8.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_hazard  in  1  CPU stall. While high, no bus side effects occur and DIO_out holds its value.
- IO_address  in  16  IO address.
- IO_ren  in  1  IO read strobe.
- IO_wren  in  1  IO write strobe.
- h_en  in  1  high-byte enable.
- l_en  in  1  low-byte enable.
- IO_wdata  in  16  write data.
- DIO_out  out  16  registered read data, returned to the CPU's DIO_in.
- tx_data  out  16  TX stream data (head of the TX FIFO).
- tx_valid  out  1  TX stream valid.
- tx_ready  in  1  TX stream ready.
- rx_data  in  16  RX stream data.
- rx_valid  in  1  RX stream valid.
- rx_ready  out  1  RX stream ready.
- irq  out  1  interrupt request, level, active-high.

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: DIO_out=0, both FIFOs empty, CONTROL=0, sticky flags=0, tx_valid=0, rx_ready=0 while rst is high, irq=0.
- Byte lanes:
  - hi_lane = h_en | ~l_en; lo_lane = ~h_en | l_en.
  - h_en=l_en=0 selects both bytes.
- Accepted access:
  - rd = IO_ren & hit & ~data_hazard.
  - wr = IO_wren & hit & ~data_hazard.
  - IO_ren and IO_wren both high in one cycle: the write is performed; DIO_out loads as for a read of the same offset, but it shows pre-write state and there is no RX pop.
- Read latency: DIO_out is updated on the edge that samples rd and holds until the next accepted read.
  - IO_ren with no hit and no hazard loads DIO_out=0, so responders can be OR-combined.
- Register map (offset):
  - 0 DATA
    - Write: pushes {hi_lane?IO_wdata[15:8]:0, lo_lane?IO_wdata[7:0]:0} into the TX FIFO.
    - Read: pops the RX head into DIO_out.
  - 1 STATUS
    - Read-only fields: [0] rx_nonempty, [1] tx_full, [2] tx_empty, [3] rx_full, [4] tx_ovf, [5] rx_unf, [11:8] rx_count, [15:12] tx_count. All other bits read 0.
    - Write with lo_lane: 1 in bit 4 or 5 clears that sticky flag. Other bits are ignored.
  - 2 CONTROL
    - Fields: [0] rx_irq_en, [1] tx_irq_en, [15] flush.
    - Byte-lane masked write.
    - flush is self-clearing: it acts on the write edge and reads back 0.
  - 3 reserved: reads 0, writes ignored.
- Full/empty tests use the registered counts from before the edge.
  - Write to DATA while TX is full: data dropped, tx_ovf<=1, even if a TX pop happens in the same cycle.
  - Read of DATA while RX is empty: DIO_out<=0, rx_unf<=1, even if an RX push happens in the same cycle.
  - Setting a sticky flag has priority over a same-cycle W1C clear.
- TX stream:
  - tx_valid = ~tx_empty; tx_data = TX head.
  - Pop on tx_valid & tx_ready.
  - tx_data is stable while tx_valid & ~tx_ready.
- RX stream:
  - rx_ready = ~rx_full & ~rst.
  - Push on rx_valid & rx_ready.
- Simultaneous push and pop on one FIFO: both happen, count unchanged. Pointers wrap modulo DEPTH.
- Flush: both FIFOs empty after the edge. Any same-cycle push or pop on either FIFO is discarded; a same-cycle DATA read returns 0 without setting rx_unf.
- irq = (rx_irq_en & rx_nonempty) | (tx_irq_en & tx_empty), computed from registered state.
- data_hazard high: no push/pop by the CPU side, no register writes, DIO_out held. Stream-side transfers continue.
- rst asserted mid-transfer: all state clears immediately; an in-flight stream beat is lost.

Test Plan:
- Reset, then read STATUS → DIO_out=16'h0004 one cycle after IO_ren; tx_valid=0; rx_ready=1.
- With tx_ready=0, write 16'hA5C3 to DATA with h_en=l_en=0 → tx_valid=1, tx_data=16'hA5C3, STATUS[15:12]=1. Raise tx_ready → pop in one cycle, tx_empty=1.
- Write 9 words with tx_ready=0 (DEPTH=8) → 9th word dropped, STATUS=16'h8012. Write 16'h0010 to STATUS → tx_ovf cleared.
- Drive rx_valid with 16'h1234 then 16'h5678 → two DATA reads return 16'h1234 then 16'h5678. A third read returns 0 and sets rx_unf.
- Set CONTROL=16'h0001, push one RX word → irq=1. Write CONTROL=16'h8001 → both FIFOs empty, irq=0.
- Hold data_hazard=1 across a DATA read and a DATA write → no pop, no push, DIO_out unchanged. A read at IO_address=16'h1234 (no hit) → DIO_out=0.

Source files
------------

// File: rtl/io_stream_port_if.sv
// CPU IO-bus and stream signals of io_stream_port, bundled so the bench and the
// block share one definition. slave is the block's view, master the surroundings'.
interface io_stream_port_if;
  logic        data_hazard;
  logic [15:0] IO_address;
  logic        IO_ren;
  logic        IO_wren;
  logic        h_en;
  logic        l_en;
  logic [15:0] IO_wdata;
  logic [15:0] DIO_out;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        irq;

  modport slave (
    input  data_hazard, IO_address, IO_ren, IO_wren, h_en, l_en, IO_wdata,
    input  tx_ready, rx_data, rx_valid,
    output DIO_out, tx_data, tx_valid, rx_ready, irq
  );

  modport master (
    output data_hazard, IO_address, IO_ren, IO_wren, h_en, l_en, IO_wdata,
    output tx_ready, rx_data, rx_valid,
    input  DIO_out, tx_data, tx_valid, rx_ready, irq
  );
endinterface

// File: rtl/io_stream_port.sv
// NeonFox IO-space responder: CPU DATA writes feed a TX stream FIFO, an RX stream
// FIFO is popped by DATA reads, plus STATUS/CONTROL registers and a level interrupt.
module io_stream_port #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          DEPTH     = 8
) (
  input logic             clk,
  input logic             rst,
  io_stream_port_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [15:0]   tx_mem [DEPTH];
  logic [15:0]   rx_mem [DEPTH];
  logic [PW-1:0] tx_rd_ptr, tx_wr_ptr, rx_rd_ptr, rx_wr_ptr;
  logic [CW-1:0] tx_count, rx_count;
  logic          rx_irq_en, tx_irq_en, tx_ovf, rx_unf;
  logic [15:0]   dio_q;

  logic          hit, hi_lane, lo_lane, rd, wr;
  logic [1:0]    offset;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          flush, data_wr, data_rd, tx_push, tx_pop, rx_push, rx_pop;
  logic [15:0]   wr_data, status, rd_mux;

  assign hit     = bus.IO_address[15:2] == BASE_ADDR[15:2];
  assign offset  = bus.IO_address[1:0];
  assign hi_lane = bus.h_en | ~bus.l_en;
  assign lo_lane = ~bus.h_en | bus.l_en;
  assign rd      = bus.IO_ren & hit & ~bus.data_hazard;
  assign wr      = bus.IO_wren & hit & ~bus.data_hazard;
  assign wr_data = {hi_lane ? bus.IO_wdata[15:8] : 8'h00,
                    lo_lane ? bus.IO_wdata[7:0]  : 8'h00};

  assign tx_full  = tx_count == CW'(DEPTH);
  assign tx_empty = tx_count == '0;
  assign rx_full  = rx_count == CW'(DEPTH);
  assign rx_empty = rx_count == '0;

  // A combined read+write performs the write only, so it never pops RX.
  assign flush   = wr & (offset == 2'd2) & hi_lane & bus.IO_wdata[15];
  assign data_wr = wr & (offset == 2'd0);
  assign data_rd = rd & ~bus.IO_wren & (offset == 2'd0);
  assign tx_push = data_wr & ~tx_full & ~flush;
  assign tx_pop  = ~tx_empty & bus.tx_ready & ~flush;
  assign rx_push = bus.rx_valid & ~rx_full & ~flush;
  assign rx_pop  = data_rd & ~rx_empty & ~flush;

  assign status = {4'(tx_count), 4'(rx_count), 2'b00, rx_unf, tx_ovf,
                   rx_full, tx_empty, tx_full, ~rx_empty};

  always_comb begin
    rd_mux = 16'h0000;
    case (offset)
      2'd0:    rd_mux = rx_empty ? 16'h0000 : rx_mem[rx_rd_ptr];
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = {14'b0, tx_irq_en, rx_irq_en};
      default: rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= wr_data;
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_count  <= '0;
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_count  <= '0;
      rx_irq_en <= 1'b0;
      tx_irq_en <= 1'b0;
      tx_ovf    <= 1'b0;
      rx_unf    <= 1'b0;
      dio_q     <= 16'h0000;
    end else begin
      if (flush) begin
        tx_rd_ptr <= '0;
        tx_wr_ptr <= '0;
        tx_count  <= '0;
        rx_rd_ptr <= '0;
        rx_wr_ptr <= '0;
        rx_count  <= '0;
      end else begin
        if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
        if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
        if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
        if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
        tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
        rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
      end

      if (wr && offset == 2'd2 && lo_lane) begin
        rx_irq_en <= bus.IO_wdata[0];
        tx_irq_en <= bus.IO_wdata[1];
      end

      // Clears come first so a same-cycle set wins.
      if (wr && offset == 2'd1 && lo_lane) begin
        if (bus.IO_wdata[4]) tx_ovf <= 1'b0;
        if (bus.IO_wdata[5]) rx_unf <= 1'b0;
      end
      if (data_wr && tx_full)           tx_ovf <= 1'b1;
      if (data_rd && rx_empty && !flush) rx_unf <= 1'b1;

      if (bus.IO_ren && !bus.data_hazard)
        dio_q <= (hit && !(flush && offset == 2'd0)) ? rd_mux : 16'h0000;
    end
  end

  assign bus.DIO_out  = dio_q;
  assign bus.tx_data  = tx_mem[tx_rd_ptr];
  assign bus.tx_valid = ~tx_empty;
  assign bus.rx_ready = ~rx_full & ~rst;
  assign bus.irq      = (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty);
endmodule

// File: tb/tb_io_stream_port.sv
// Directed bench for io_stream_port: stimulus queues expected DIO_out reads and TX
// beats, a negedge monitor pops and compares them as the block presents them.
module tb_io_stream_port;
  localparam logic [15:0] A_DATA   = 16'hFF00;
  localparam logic [15:0] A_STATUS = 16'hFF01;
  localparam logic [15:0] A_CTRL   = 16'hFF02;
  localparam logic [15:0] A_RSVD   = 16'hFF03;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  logic [15:0] exp_rd_q [$];
  string       rd_name_q [$];
  logic [15:0] exp_tx_q [$];
  logic        rd_pending = 1'b0;

  io_stream_port_if bus ();

  io_stream_port #(.BASE_ADDR(16'hFF00), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  // Reads sampled on one edge are checked at the following negedge; TX beats are
  // checked at the negedge before the edge that transfers them.
  always @(negedge clk) begin : monitor
    string n;
    if (rd_pending) begin
      if (exp_rd_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL rd_unexpected: got 0x%04h, expected no read", bus.DIO_out);
      end else begin
        n = rd_name_q.pop_front();
        check_output(n, bus.DIO_out, exp_rd_q.pop_front());
      end
    end
    rd_pending = !rst && bus.IO_ren && !bus.data_hazard;
    if (!rst && bus.tx_valid && bus.tx_ready) begin
      if (exp_tx_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL tx_unexpected: got 0x%04h, expected no beat", bus.tx_data);
      end else begin
        check_output("tx_beat", bus.tx_data, exp_tx_q.pop_front());
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic ren, input logic wren, input logic [15:0] addr,
                                input logic [15:0] data, input logic h, input logic l,
                                input logic hazard, input logic [15:0] exp,
                                input string name);
    bus.IO_ren      = ren;
    bus.IO_wren     = wren;
    bus.IO_address  = addr;
    bus.IO_wdata    = data;
    bus.h_en        = h;
    bus.l_en        = l;
    bus.data_hazard = hazard;
    if (ren && !hazard) begin
      exp_rd_q.push_back(exp);
      rd_name_q.push_back(name);
    end
    sync();
    bus.IO_ren      = 1'b0;
    bus.IO_wren     = 1'b0;
    bus.h_en        = 1'b0;
    bus.l_en        = 1'b0;
    bus.data_hazard = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data,
                           input logic h, input logic l);
    apply_stimulus(1'b0, 1'b1, addr, data, h, l, 1'b0, 16'h0000, "");
  endtask

  task automatic bus_read(input logic [15:0] addr, input logic [15:0] exp, input string name);
    apply_stimulus(1'b1, 1'b0, addr, 16'h0000, 1'b0, 1'b0, 1'b0, exp, name);
  endtask

  task automatic tx_write(input logic [15:0] data, input logic h, input logic l,
                          input logic [15:0] exp, input logic accepted);
    bus_write(A_DATA, data, h, l);
    if (accepted) exp_tx_q.push_back(exp);
  endtask

  task automatic rx_beat(input logic [15:0] data);
    bus.rx_data  = data;
    bus.rx_valid = 1'b1;
    sync();
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    bus.data_hazard = 1'b0;
    bus.IO_address  = 16'h0000;
    bus.IO_ren      = 1'b0;
    bus.IO_wren     = 1'b0;
    bus.h_en        = 1'b0;
    bus.l_en        = 1'b0;
    bus.IO_wdata    = 16'h0000;
    bus.tx_ready    = 1'b0;
    bus.rx_data     = 16'h0000;
    bus.rx_valid    = 1'b0;
    sync();
    check_output("rst_dio", bus.DIO_out, 16'h0000);
    check_output("rst_tx_valid", 16'(bus.tx_valid), 16'h0000);
    check_output("rst_irq", 16'(bus.irq), 16'h0000);
    check_output("rst_rx_ready", 16'(bus.rx_ready), 16'h0000);
    rst = 1'b0;
    #1;
    check_output("rx_ready_after_rst", 16'(bus.rx_ready), 16'h0001);
    sync();

    bus_read(A_STATUS, 16'h0004, "status_reset");

    // Single full-word TX write, then one-cycle drain.
    tx_write(16'hA5C3, 1'b0, 1'b0, 16'hA5C3, 1'b1);
    check_output("tx_valid_after_write", 16'(bus.tx_valid), 16'h0001);
    check_output("tx_data_head", bus.tx_data, 16'hA5C3);
    bus_read(A_STATUS, 16'h1000, "status_tx_one");
    bus.tx_ready = 1'b1;
    sync();
    bus.tx_ready = 1'b0;
    check_output("tx_valid_after_pop", 16'(bus.tx_valid), 16'h0000);
    bus_read(A_STATUS, 16'h0004, "status_tx_drained");

    // Byte-lane writes, fill to DEPTH, then an overflowing ninth write.
    tx_write(16'hBEEF, 1'b1, 1'b0, 16'hBE00, 1'b1);
    tx_write(16'h1234, 1'b0, 1'b1, 16'h0034, 1'b1);
    for (int i = 0; i < 6; i++)
      tx_write(16'h0100 + 16'(i), 1'b0, 1'b0, 16'h0100 + 16'(i), 1'b1);
    tx_write(16'hDEAD, 1'b1, 1'b1, 16'h0000, 1'b0);
    check_output("tx_hold_stalled", bus.tx_data, 16'hBE00);
    bus_read(A_STATUS, 16'h8012, "status_tx_ovf");
    bus_write(A_STATUS, 16'h0010, 1'b0, 1'b0);
    bus_read(A_STATUS, 16'h8002, "status_ovf_cleared");
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) sync();
    bus.tx_ready = 1'b0;
    bus_read(A_STATUS, 16'h0004, "status_tx_empty_again");

    // RX stream in, CPU pops, then underflow and its lane-gated clear.
    rx_beat(16'h1234);
    rx_beat(16'h5678);
    bus_read(A_STATUS, 16'h0205, "status_rx_two");
    bus_read(A_DATA, 16'h1234, "rx_pop_first");
    bus_read(A_DATA, 16'h5678, "rx_pop_second");
    bus_read(A_DATA, 16'h0000, "rx_pop_empty");
    bus_read(A_STATUS, 16'h0024, "status_rx_unf");
    bus_write(A_STATUS, 16'h0020, 1'b1, 1'b0);
    bus_read(A_STATUS, 16'h0024, "status_unf_hi_lane_only");
    bus_write(A_STATUS, 16'h0020, 1'b0, 1'b1);
    bus_read(A_STATUS, 16'h0004, "status_unf_cleared");

    // RX interrupt, fill RX to full, flush with a high-byte-only CONTROL write.
    bus_write(A_CTRL, 16'h0001, 1'b0, 1'b0);
    check_output("irq_rx_empty", 16'(bus.irq), 16'h0000);
    rx_beat(16'h00AA);
    check_output("irq_rx_nonempty", 16'(bus.irq), 16'h0001);
    for (int i = 0; i < 7; i++) rx_beat(16'h0B00 + 16'(i));
    check_output("rx_ready_full", 16'(bus.rx_ready), 16'h0000);
    bus_read(A_STATUS, 16'h080D, "status_rx_full");
    bus_write(A_CTRL, 16'h8000, 1'b1, 1'b0);
    check_output("irq_after_flush", 16'(bus.irq), 16'h0000);
    check_output("rx_ready_after_flush", 16'(bus.rx_ready), 16'h0001);
    bus_read(A_STATUS, 16'h0004, "status_after_flush");
    bus_read(A_CTRL, 16'h0001, "ctrl_after_flush");
    bus_write(A_CTRL, 16'h0000, 1'b0, 1'b0);

    // Stalled accesses have no side effects; a miss reads as zero.
    rx_beat(16'h7777);
    apply_stimulus(1'b1, 1'b0, A_DATA, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, "");
    apply_stimulus(1'b0, 1'b1, A_DATA, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h0000, "");
    check_output("dio_held_hazard", bus.DIO_out, 16'h0001);
    check_output("tx_valid_hazard", 16'(bus.tx_valid), 16'h0000);
    bus_read(A_STATUS, 16'h0105, "status_after_hazard");
    bus_read(A_DATA, 16'h7777, "rx_pop_after_hazard");
    bus_read(16'h1234, 16'h0000, "read_no_hit");

    // Reserved offset, and a combined read+write returning pre-write CONTROL.
    bus_write(A_RSVD, 16'hFFFF, 1'b0, 1'b0);
    bus_read(A_RSVD, 16'h0000, "reserved_read");
    bus_write(A_CTRL, 16'h0002, 1'b0, 1'b0);
    check_output("irq_tx_empty", 16'(bus.irq), 16'h0001);
    bus_read(A_CTRL, 16'h0002, "ctrl_readback");
    apply_stimulus(1'b1, 1'b1, A_CTRL, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0002, "ctrl_rw_prewrite");
    bus_read(A_CTRL, 16'h0001, "ctrl_after_rw");
    check_output("irq_rx_en_empty", 16'(bus.irq), 16'h0000);

    sync();
    sync();
    check_output("rd_queue_left", 16'(exp_rd_q.size()), 16'h0000);
    check_output("tx_queue_left", 16'(exp_tx_q.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
